// File: rtl/stack_seq.sv
// 6502-style stack push/pull sequencer: moves 1..3 bytes over the memory bus
// and hands each updated stack pointer back to the S register one cycle later.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// XFER  | one bus transfer per byte, sp stepped on every handshake
// DONE  | one-cycle completion pulse, last s_load coincides with it
module stack_seq #(
    parameter logic [7:0] STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic        cmd_push,
    input  logic [1:0]  cmd_len,
    input  logic [23:0] cmd_data,
    output logic        cmd_ready,
    output logic        busy,
    output logic        done,
    output logic [23:0] pull_data,
    input  logic [7:0]  s_cur,
    output logic        s_load,
    output logic [7:0]  s_next,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        op;
    logic [1:0]  len;
    logic [23:0] data;
    logic [7:0]  sp;
    logic [1:0]  cnt;

    logic        accept;
    logic        handshake;
    logic        last_byte;
    logic [7:0]  sp_upd;
    logic [1:0]  byte_idx;

    assign accept    = (state == IDLE) && cmd_valid && (cmd_len != 2'd0);
    assign handshake = (state == XFER) && mem_ready;
    assign last_byte = ({1'b0, cnt} + 3'd1) == {1'b0, len};
    assign sp_upd    = op ? (sp - 8'd1) : (sp + 8'd1);
    // highest byte of the payload goes out first
    assign byte_idx  = len - 2'd1 - cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = op;
                if (op) begin
                    mem_addr = {STACK_PAGE, sp};
                    case (byte_idx)
                        2'd0:    mem_wdata = data[7:0];
                        2'd1:    mem_wdata = data[15:8];
                        2'd2:    mem_wdata = data[23:16];
                        default: mem_wdata = 8'h00;
                    endcase
                end else begin
                    mem_addr = {STACK_PAGE, sp + 8'd1};
                end
                if (handshake && last_byte) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= 1'b0;
            len       <= 2'd0;
            data      <= 24'h0;
            sp        <= 8'h00;
            cnt       <= 2'd0;
            pull_data <= 24'h0;
            s_load    <= 1'b0;
            s_next    <= 8'h00;
        end else begin
            s_load <= handshake;
            if (accept) begin
                op        <= cmd_push;
                len       <= cmd_len;
                data      <= cmd_data;
                sp        <= s_cur;
                cnt       <= 2'd0;
                pull_data <= 24'h0;
            end
            if (handshake) begin
                sp     <= sp_upd;
                s_next <= sp_upd;
                cnt    <= cnt + 2'd1;
                if (!op) begin
                    case (cnt)
                        2'd0:    pull_data[7:0]   <= mem_rdata;
                        2'd1:    pull_data[15:8]  <= mem_rdata;
                        2'd2:    pull_data[23:16] <= mem_rdata;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: directed test-plan cases plus random commands, checked
// against a page-1 memory array and stack arithmetic computed per byte.
module tb_stack_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_push = 1'b0;
    logic [1:0]  cmd_len = 2'd0;
    logic [23:0] cmd_data = 24'h0;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic [23:0] pull_data;
    logic [7:0]  s_cur = 8'h00;
    logic        s_load;
    logic [7:0]  s_next;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready = 1'b0;

    int total = 0;
    int bad = 0;
    logic [7:0]  mem [256];
    logic [23:0] pulled;

    stack_seq #(.STACK_PAGE(8'h01)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_push(cmd_push), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .busy(busy), .done(done),
        .pull_data(pull_data), .s_cur(s_cur), .s_load(s_load), .s_next(s_next),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one command and acts as the memory; wfix < 0 picks 0..3 wait cycles per byte.
    task automatic run_cmd(input bit push, input int len, input logic [23:0] data,
                           input logic [7:0] s0, input int wfix, input bit hold_valid,
                           output logic [23:0] got);
        logic [23:0] exp_pd;
        logic [7:0]  a;
        logic [7:0]  wb;
        int          w;
        exp_pd = 24'h0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_push = push; cmd_len = len[1:0];
        cmd_data = data; s_cur = s0; mem_ready = 1'b0;
        chk("ready_before", cmd_ready, 1);
        @(negedge clk);
        if (hold_valid) begin
            cmd_push = ~push; cmd_len = 2'd3; cmd_data = 24'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        for (int k = 0; k < len; k++) begin
            a  = push ? 8'(s0 - k) : 8'(s0 + 1 + k);
            wb = push ? data[8*(len-1-k) +: 8] : 8'h00;
            w  = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
            for (int c = 0; c <= w; c++) begin
                chk("xfer_req", mem_req, 1);
                chk("xfer_busy", busy, 1);
                chk("xfer_done", done, 0);
                chk("xfer_we", mem_we, push);
                chk("xfer_addr", mem_addr, {8'h01, a});
                chk("xfer_wdata", mem_wdata, wb);
                chk("xfer_sload", s_load, (c == 0 && k > 0));
                if (c == 0 && k > 0)
                    chk("xfer_snext", s_next, push ? 8'(s0 - k) : 8'(s0 + k));
                s_cur = 8'($urandom);
                mem_ready = (c == w);
                mem_rdata = mem[a];
                if (c == w) begin
                    if (push) mem[a] = wb;
                    else exp_pd[8*k +: 8] = mem[a];
                end
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        mem_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_req", mem_req, 0);
        chk("done_ready", cmd_ready, 0);
        chk("done_sload", s_load, 1);
        chk("done_snext", s_next, push ? 8'(s0 - len) : 8'(s0 + len));
        chk("done_pdata", pull_data, exp_pd);
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_sload", s_load, 0);
        chk("idle_req", mem_req, 0);
        chk("idle_pdata", pull_data, exp_pd);
        got = pull_data;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        #12;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_sload", s_load, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_snext", s_next, 0);
        chk("rst_pdata", pull_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(1'b1, 3, 24'h123456, 8'hFD, 0, 1'b0, pulled);
        chk("push3_pdata_zero", pulled, 24'h0);
        run_cmd(1'b0, 3, 24'h0, 8'hFA, 0, 1'b0, pulled);
        chk("pull3_value", pulled, 24'h123456);

        run_cmd(1'b1, 2, 24'h00AABB, 8'h00, 0, 1'b0, pulled);
        run_cmd(1'b0, 1, 24'h0, 8'hFF, 0, 1'b0, pulled);
        chk("wrap_pull_value", pulled, 24'h0000AA);

        run_cmd(1'b1, 1, 24'h00005A, 8'h40, 3, 1'b0, pulled);
        run_cmd(1'b0, 2, 24'h0, 8'h30, 1, 1'b1, pulled);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 2'd0; cmd_push = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("len0_busy", busy, 0);
            chk("len0_req", mem_req, 0);
            chk("len0_ready", cmd_ready, 1);
        end
        cmd_valid = 1'b0;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_push = 1'b0; cmd_len = 2'd3; s_cur = 8'h80; mem_ready = 1'b1;
        mem_rdata = 8'h77;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_sload", s_load, 1);
        chk("rstmid_snext", s_next, 8'h81);
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", mem_req, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_pdata", pull_data, 0);
        chk("rstmid_sload0", s_load, 0);
        chk("rstmid_addr", mem_addr, 0);
        chk("rstmid_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_sload", s_load, 0);
            chk("post_rst_busy", busy, 0);
        end

        run_cmd(1'b1, 3, 24'hC0FFEE, 8'h10, 0, 1'b0, pulled);
        run_cmd(1'b0, 3, 24'h0, 8'h0D, 2, 1'b0, pulled);
        chk("post_rst_pull", pulled, 24'hC0FFEE);

        for (int n = 0; n < 30; n++) begin
            run_cmd(1'($urandom), int'($urandom_range(1, 3)), 24'($urandom),
                    8'($urandom), -1, 1'($urandom), pulled);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
